// File: rtl/insn_decode_fifo.sv
// insn_decode_fifo
//   Decodes instruction words into class fields and buffers the decoded
//   records in a DEPTH-entry FIFO for the execute/issue stage.
//   Optional per-class saturating counters are built when the macro
//   DECODE_STATS_EN is defined; otherwise the counter ports read 0.
//
// Parameters
//   INSN_W  instruction width (>= 28, decode looks at bits [27:20])
//   DEPTH   FIFO entries (power of two, >= 2)
//   CNT_W   statistics counter width
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_insn is the word
//   out_valid/out_ready downstream handshake for the head record
//   out_insn, out_ins_type, out_data_type, out_mem_type, out_branch_type
//                       head record fields
//   flush               drop all buffered records
//   clr_stats           zero the counters
//   cnt_data, cnt_mem, cnt_branch, cnt_other
//                       accepted-instruction counts per class
module insn_decode_fifo #(
  parameter int INSN_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INSN_W-1:0] in_insn,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [1:0]        out_ins_type,
  output logic [2:0]        out_data_type,
  output logic [1:0]        out_mem_type,
  output logic [1:0]        out_branch_type,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  cnt_data,
  output logic [CNT_W-1:0]  cnt_mem,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_other
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    CLS_DATA   = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_OTHER  = 2'b11
  } ins_class_t;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [1:0]        ins_type;
    logic [2:0]        data_type;
    logic [1:0]        mem_type;
    logic [1:0]        branch_type;
  } rec_t;

  rec_t        dec;
  rec_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Decode of the incoming word
  always_comb begin
    dec             = '0;
    dec.insn        = in_insn;
    dec.ins_type    = in_insn[27:26];
    unique case (ins_class_t'(in_insn[27:26]))
      CLS_DATA:   dec.data_type   = in_insn[23:21];
      CLS_MEM:    dec.mem_type    = {in_insn[20], in_insn[22]};
      CLS_BRANCH: dec.branch_type = in_insn[25:24];
      default:    ;
    endcase
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready is forced high in reset: whatever is presented is dropped there.
  assign in_ready  = rst || !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready && !flush && !rst;
  assign pop  = out_valid && out_ready && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr[AW-1:0]] <= dec;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign out_insn        = mem_q[rd_ptr[AW-1:0]].insn;
  assign out_ins_type    = mem_q[rd_ptr[AW-1:0]].ins_type;
  assign out_data_type   = mem_q[rd_ptr[AW-1:0]].data_type;
  assign out_mem_type    = mem_q[rd_ptr[AW-1:0]].mem_type;
  assign out_branch_type = mem_q[rd_ptr[AW-1:0]].branch_type;

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (push && (cnt_q[dec.ins_type] != '1)) begin
      cnt_q[dec.ins_type] <= cnt_q[dec.ins_type] + 1'b1;
    end
  end

  assign cnt_data   = cnt_q[CLS_DATA];
  assign cnt_mem    = cnt_q[CLS_MEM];
  assign cnt_branch = cnt_q[CLS_BRANCH];
  assign cnt_other  = cnt_q[CLS_OTHER];
`else
  // Without statistics the counters are constant zero; clr_stats is folded
  // in only so the port is not left dangling, it cannot change the value.
  logic [CNT_W-1:0] zero_cnt;
  assign zero_cnt   = '0 & {CNT_W{clr_stats}};
  assign cnt_data   = zero_cnt;
  assign cnt_mem    = zero_cnt;
  assign cnt_branch = zero_cnt;
  assign cnt_other  = zero_cnt;
`endif

endmodule

// File: tb/tb_insn_decode_fifo.sv
// tb_insn_decode_fifo
//   Directed bench for insn_decode_fifo with DEPTH = 4 and CNT_W = 2, so
//   counter saturation is reachable. Counter expectations are the
//   hand-computed totals when DECODE_STATS_EN is defined, 0 otherwise.
module tb_insn_decode_fifo;

  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
`ifdef DECODE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [INSN_W-1:0] in_insn;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [INSN_W-1:0] out_insn;
  logic [1:0]        out_ins_type;
  logic [2:0]        out_data_type;
  logic [1:0]        out_mem_type;
  logic [1:0]        out_branch_type;
  logic              flush;
  logic              clr_stats;
  logic [CNT_W-1:0]  cnt_data;
  logic [CNT_W-1:0]  cnt_mem;
  logic [CNT_W-1:0]  cnt_branch;
  logic [CNT_W-1:0]  cnt_other;

  int n_checks = 0;
  int n_fail   = 0;

  insn_decode_fifo #(
    .INSN_W(INSN_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_insn        (in_insn),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_ins_type   (out_ins_type),
    .out_data_type  (out_data_type),
    .out_mem_type   (out_mem_type),
    .out_branch_type(out_branch_type),
    .flush          (flush),
    .clr_stats      (clr_stats),
    .cnt_data       (cnt_data),
    .cnt_mem        (cnt_mem),
    .cnt_branch     (cnt_branch),
    .cnt_other      (cnt_other)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ce(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic check_cnts(input string tag, input int d, input int m,
                            input int b, input int o);
    check_eq({tag, ".cnt_data"},   64'(cnt_data),   64'(ce(d)));
    check_eq({tag, ".cnt_mem"},    64'(cnt_mem),    64'(ce(m)));
    check_eq({tag, ".cnt_branch"}, 64'(cnt_branch), 64'(ce(b)));
    check_eq({tag, ".cnt_other"},  64'(cnt_other),  64'(ce(o)));
  endtask

  task automatic check_head(input string tag, input logic [31:0] insn,
                            input logic [1:0] it, input logic [2:0] dt,
                            input logic [1:0] mt, input logic [1:0] bt);
    check_eq({tag, ".valid"},  64'(out_valid),       64'(1));
    check_eq({tag, ".insn"},   64'(out_insn),        64'(insn));
    check_eq({tag, ".itype"},  64'(out_ins_type),    64'(it));
    check_eq({tag, ".dtype"},  64'(out_data_type),   64'(dt));
    check_eq({tag, ".mtype"},  64'(out_mem_type),    64'(mt));
    check_eq({tag, ".btype"},  64'(out_branch_type), 64'(bt));
  endtask

  localparam logic [31:0] W_DATA = 32'h03FA_D394; // data, data_type 7
  localparam logic [31:0] W_MEM  = 32'h27CD_A5E8; // memory, mem_type 01
  localparam logic [31:0] W_BR   = 32'hEA00_0010; // branch, branch_type 10

  logic [31:0] wq [5];
  logic [31:0] sq [12];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; out_ready = 1'b0;
    flush = 1'b0; clr_stats = 1'b0;
    for (int i = 0; i < 5; i++)  wq[i] = 32'h0C00_0000 + 32'(i);  // other
    for (int i = 0; i < 12; i++) sq[i] = 32'h1000_0000 + 32'(i);  // data

    // Reset
    tick();
    check_eq("rst.in_ready_during", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst.in_ready",  64'(in_ready),  64'(1));
    check_eq("rst.out_valid", 64'(out_valid), 64'(0));
    check_eq("rst.out_insn",  64'(out_insn),  64'(0));
    check_eq("rst.fields", 64'({out_ins_type, out_data_type, out_mem_type,
                                out_branch_type}), 64'(0));
    check_cnts("rst", 0, 0, 0, 0);

    // Single data push, one-cycle latency
    in_valid = 1'b1; in_insn = W_DATA;
    tick();
    in_valid = 1'b0;
    check_head("data", W_DATA, 2'b00, 3'd7, 2'b00, 2'b00);
    check_cnts("data", 1, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("data.popped", 64'(out_valid), 64'(0));

    // Memory then branch back-to-back, order preserved
    in_valid = 1'b1; in_insn = W_MEM;
    tick();
    in_insn = W_BR;
    tick();
    in_valid = 1'b0;
    check_head("mem", W_MEM, 2'b01, 3'd0, 2'b01, 2'b00);
    out_ready = 1'b1;
    tick();
    check_head("br", W_BR, 2'b10, 3'd0, 2'b00, 2'b10);
    tick();
    out_ready = 1'b0;
    check_eq("mb.empty", 64'(out_valid), 64'(0));
    check_cnts("mb", 1, 1, 1, 0);

    // Fill to full, extra word held off until a pop frees a slot
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_insn = wq[i];
      tick();
    end
    check_eq("full.in_ready", 64'(in_ready), 64'(0));
    in_insn = wq[4];
    tick();
    check_eq("full.held", 64'(in_ready), 64'(0));
    check_eq("full.head", 64'(out_insn), 64'(wq[0]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("full.freed", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check_eq("full.refill", 64'(in_ready), 64'(0));
    check_cnts("full", 1, 1, 1, 3);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_eq("full.order", 64'(out_insn), 64'(wq[i]));
      tick();
    end
    out_ready = 1'b0;
    check_eq("full.drained", 64'(out_valid), 64'(0));

    // Half full, push and pop together across pointer wrap
    in_valid = 1'b1;
    in_insn = sq[0]; tick();
    in_insn = sq[1]; tick();
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_insn = sq[j + 2];
      check_eq("stream.order", 64'(out_insn), 64'(sq[j]));
      tick();
      check_eq("stream.valid", 64'(out_valid), 64'(1));
      check_eq("stream.ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    check_eq("stream.tail0", 64'(out_insn), 64'(sq[10]));
    tick();
    check_eq("stream.tail1", 64'(out_insn), 64'(sq[11]));
    tick();
    out_ready = 1'b0;
    check_eq("stream.empty", 64'(out_valid), 64'(0));
    check_cnts("stream", 3, 1, 1, 3);

    // Counter clear, then saturation of cnt_data
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check_cnts("clr", 0, 0, 0, 0);
    in_valid = 1'b1; in_insn = W_DATA; out_ready = 1'b1;
    tick(); check_eq("sat.1", 64'(cnt_data), 64'(ce(1)));
    tick(); check_eq("sat.2", 64'(cnt_data), 64'(ce(2)));
    tick(); check_eq("sat.3", 64'(cnt_data), 64'(ce(3)));
    tick(); check_eq("sat.4", 64'(cnt_data), 64'(ce(3)));
    tick(); check_eq("sat.5", 64'(cnt_data), 64'(ce(3)));
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check_eq("sat.empty", 64'(out_valid), 64'(0));

    // clr_stats beats a same-cycle push; the push itself still lands
    clr_stats = 1'b1; in_valid = 1'b1; in_insn = W_DATA;
    tick();
    clr_stats = 1'b0; in_valid = 1'b0;
    check_eq("clrpush.cnt", 64'(cnt_data), 64'(0));
    check_eq("clrpush.valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush drops contents and the word presented with it
    in_valid = 1'b1;
    in_insn = W_MEM;  tick();
    in_insn = W_BR;   tick();
    in_insn = W_DATA; tick();
    flush = 1'b1; in_insn = 32'h0C00_00FF; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("flush.valid", 64'(out_valid), 64'(0));
    check_eq("flush.ready", 64'(in_ready), 64'(1));
    check_cnts("flush", 1, 1, 1, 0);
    in_valid = 1'b1; in_insn = W_BR;
    tick();
    in_valid = 1'b0;
    check_head("postflush", W_BR, 2'b10, 3'd0, 2'b00, 2'b10);

    // Reset mid-operation with a push in the reset cycle
    in_valid = 1'b1; in_insn = W_MEM;
    tick(); tick(); tick();
    check_eq("pre_rst.full", 64'(in_ready), 64'(0));
    rst = 1'b1;
    #1;
    check_eq("mid_rst.ready_high", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("mid_rst.valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst.insn",  64'(out_insn),  64'(0));
    check_cnts("mid_rst", 0, 0, 0, 0);
    tick();
    check_eq("mid_rst.after", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_decode_fifo.md
# insn_decode_fifo

Buffered, parametrised instruction-class decoder. Accepts instruction words over a valid/ready handshake, decodes each into the same four class fields as the existing combinational decoder, and holds the decoded records in a DEPTH-entry FIFO for the downstream stage. Optionally keeps saturating per-class instruction counters. Sits between instruction fetch and the execute/issue logic.

## Interface
- INSN_W, 32: instruction width; must be ≥ 28; decode uses bits [27:20] only.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- CNT_W, 16: statistics counter width.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_insn  in  INSN_W  instruction word.
- in_ready  out  1  FIFO can accept; = !full.
- out_valid  out  1  record available; = !empty.
- out_ready  in  1  consumer takes the head record.
- out_insn  out  INSN_W  head instruction word.
- out_ins_type  out  2  head class.
- out_data_type  out  3  head data-op field.
- out_mem_type  out  2  head memory-op field.
- out_branch_type  out  2  head branch-op field.
- flush  in  1  discard all FIFO contents.
- clr_stats  in  1  zero all counters.
- cnt_data, cnt_mem, cnt_branch, cnt_other  out  CNT_W each  accepted-instruction counters.

## Operation
- Decode (combinational on in_insn; stored on push):
  - ins_type = insn[27:26]: 00 data, 01 memory, 10 branch, 11 other.
  - data_type = insn[23:21] if data, else 0.
  - mem_type = {insn[20], insn[22]} if memory, else 0.
  - branch_type = insn[25:24] if branch, else 0.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Full: in_ready = 0. No push-through-pop bypass when full; a simultaneous pop frees the slot for the next cycle.
- Empty: out_valid = 0; no empty-to-output bypass.
- Simultaneous push and pop when neither full nor empty: both happen; occupancy unchanged.
- Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH; full/empty derive from MSB comparison.
- Head fields are undefined while out_valid = 0; the bench must not check them then.
- flush: pointers reset and FIFO empty the next cycle; a push presented in the flush cycle is dropped and not counted; a pop in that cycle is ignored.
- Counters increment by 1 per accepted push, for the class of that instruction; they saturate at 2^CNT_W−1. clr_stats takes priority over a same-cycle increment.

## Timing
- Reset: FIFO empty, in_ready = 1 in the cycle after rst deasserts and while rst is high, out_valid = 0, out_* fields = 0, all counters = 0.
- rst asserted mid-operation discards all entries and counters at that edge; a push in the reset cycle is dropped.
- Latency: word accepted at edge N into an empty FIFO gives out_valid = 1 after edge N, first visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- flush and clr_stats take effect at the edge on which they are sampled high.

## Configuration
- DECODE_STATS_EN defined: the four counters and the clr_stats logic are built as described.
- Not defined: counter ports remain present but are driven constant 0; clr_stats is ignored; FIFO behaviour is unchanged.

## Test plan
- Reset, then push 0x03FAD394 with out_ready = 0 → next cycle out_valid = 1, out_ins_type = 00, out_data_type = 7, mem/branch fields = 0, cnt_data = 1.
- Push 0x27CDA5E8 and 0xEA000010 back-to-back, then pop both → first record ins_type = 01, mem_type = 01; second record ins_type = 10, branch_type = 10; FIFO order preserved.
- With out_ready = 0, push DEPTH+1 words with in_valid held high → in_ready = 0 after DEPTH accepts; the extra word is held off. Pop once → in_ready = 1 next cycle, and the held word is accepted.
- FIFO half full, assert push and pop in the same cycle for 10 cycles → occupancy constant, data stream order correct across pointer wrap.
- Push 3 words, then flush with in_valid = 1 → next cycle out_valid = 0, the word at the flush edge is not counted, counters hold their pre-flush totals.
- DECODE_STATS_EN with CNT_W = 2: push 5 data instructions → cnt_data = 3. Assert clr_stats with a same-cycle push → 0. Without the macro, all counters read 0 throughout.
